block_pipe: RTL and testbench

Parametrised successor to the two-flop NAND/inverter timing cell. It is a WIDTH-bit-wide, DEPTH-stage register pipeline. Stage 0 captures the inverted `in3` bus; each later stage captures NAND(`in2`, previous stage). The output NAND stage gates the last stage with `in1`. New relative to the fixed cell:

- runtime hold and loop modes,
- a pipeline-primed flag,
- a saturating output-toggle counter.

It sits in the generated timing-test designs wherever a multi-bit, variable-depth sequential path is needed.

---
 rtl/block_pipe_if.sv | 26 ++
 rtl/block_pipe.sv | 55 +++++
 tb/tb_block_pipe.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/block_pipe_if.sv
// Channel bundle for block_pipe: gate/data buses, mode controls and the
// registered result signals. The master drives the controls; the pipe is the slave.
interface block_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic             hold;
  logic             loop;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic             out_valid;
  logic [CNT_W-1:0] toggle_cnt;

  modport master (
    output in1, in2, in3, hold, loop,
    input  out1, out2, out_valid, toggle_cnt
  );

  modport slave (
    input  in1, in2, in3, hold, loop,
    output out1, out2, out_valid, toggle_cnt
  );
endinterface

// File: rtl/block_pipe.sv
// WIDTH-bit, DEPTH-stage NAND/inverter register pipeline with hold, loop-back,
// primed flag and a saturating count of edges on which the last stage changed.
module block_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  block_pipe_if.slave   bus,
  output logic          clkout
);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [WIDTH-1:0]  s_reg  [DEPTH];
  logic [WIDTH-1:0]  s_next [DEPTH];
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_next;
  logic              valid_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              toggle;

  // Stage 0 optionally closes the ring through the last stage.
  assign s_next[0] = bus.loop ? ~(~bus.in3 & s_reg[DEPTH-1]) : ~bus.in3;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
      assign s_next[gi] = ~(bus.in2 & s_reg[gi-1]);
    end
  endgenerate

  assign fill_next = (fill_reg == FILL_MAX) ? FILL_MAX : fill_reg + 1'b1;
  assign toggle    = (s_next[DEPTH-1] != s_reg[DEPTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) s_reg[k] <= '0;
      fill_reg  <= '0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (!bus.hold) begin
      for (int k = 0; k < DEPTH; k++) s_reg[k] <= s_next[k];
      fill_reg  <= fill_next;
      valid_reg <= (fill_next == FILL_MAX);
      if (toggle && (cnt_reg != '1)) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.out2       = s_reg[DEPTH-1];
  assign bus.out1       = ~(bus.in1 & s_reg[DEPTH-1]);
  assign bus.out_valid  = valid_reg;
  assign bus.toggle_cnt = cnt_reg;
  assign clkout         = clk;
endmodule

// File: tb/tb_block_pipe.sv
// Scoreboard bench: two pipes (DEPTH=2/CNT_W=2 and DEPTH=4/CNT_W=8) share stimulus;
// expected results are queued when a step is driven and checked after the edge.
module tb_block_pipe;
  logic clk = 1'b0;
  logic rst_n;
  logic clkout_a, clkout_b;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_step   = 0;

  always #5 clk = ~clk;

  block_pipe_if #(.WIDTH(4), .CNT_W(2)) bus_a ();
  block_pipe_if #(.WIDTH(4), .CNT_W(8)) bus_b ();

  block_pipe #(.WIDTH(4), .DEPTH(2), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .clkout(clkout_a)
  );
  block_pipe #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .clkout(clkout_b)
  );

  typedef struct {
    int         inst;
    logic [3:0] out2;
    logic [3:0] out1;
    logic       valid;
    logic [7:0] cnt;
  } exp_t;
  exp_t sbq[$];

  logic [3:0] m_s [2][4];
  int         m_fill [2];
  int         m_cnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one pipe for one clock edge.
  task automatic model_edge(input int i, input logic r, input logic h, input logic lp,
                            input logic [3:0] a2, input logic [3:0] a3);
    int d, cmax;
    logic [3:0] ns [4];
    d    = (i == 0) ? 2 : 4;
    cmax = (i == 0) ? 3 : 255;
    if (!r) begin
      for (int k = 0; k < 4; k++) m_s[i][k] = 4'h0;
      m_fill[i] = 0;
      m_cnt[i]  = 0;
    end else if (!h) begin
      ns[0] = lp ? ~(~a3 & m_s[i][d-1]) : ~a3;
      for (int k = 1; k < d; k++) ns[k] = ~(a2 & m_s[i][k-1]);
      if (ns[d-1] != m_s[i][d-1] && m_cnt[i] < cmax) m_cnt[i]++;
      if (m_fill[i] < d) m_fill[i]++;
      for (int k = 0; k < d; k++) m_s[i][k] = ns[k];
    end
  endtask

  task automatic step(input logic r, input logic h, input logic lp,
                      input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3);
    exp_t e;
    int d;
    rst_n = r;
    bus_a.hold = h; bus_a.loop = lp; bus_a.in1 = a1; bus_a.in2 = a2; bus_a.in3 = a3;
    bus_b.hold = h; bus_b.loop = lp; bus_b.in1 = a1; bus_b.in2 = a2; bus_b.in3 = a3;
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? 2 : 4;
      model_edge(i, r, h, lp, a2, a3);
      e.inst  = i;
      e.out2  = m_s[i][d-1];
      e.out1  = ~(a1 & m_s[i][d-1]);
      e.valid = (m_fill[i] == d);
      e.cnt   = 8'(m_cnt[i]);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    n_step++;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.inst == 0) begin
        check("a_out2",  {28'h0, bus_a.out2},       {28'h0, e.out2});
        check("a_out1",  {28'h0, bus_a.out1},       {28'h0, e.out1});
        check("a_valid", {31'h0, bus_a.out_valid},  {31'h0, e.valid});
        check("a_cnt",   {30'h0, bus_a.toggle_cnt}, {24'h0, e.cnt});
      end else begin
        check("b_out2",  {28'h0, bus_b.out2},       {28'h0, e.out2});
        check("b_out1",  {28'h0, bus_b.out1},       {28'h0, e.out1});
        check("b_valid", {31'h0, bus_b.out_valid},  {31'h0, e.valid});
        check("b_cnt",   {24'h0, bus_b.toggle_cnt}, {24'h0, e.cnt});
      end
    end
    check("clkout_hi", {30'h0, clkout_a, clkout_b}, 32'h3);
    $display("step %0d rst_n=%0b hold=%0b loop=%0b in1=%h in2=%h in3=%h | a: out2=%h v=%0b cnt=%0d | b: out2=%h v=%0b cnt=%0d",
             n_step, r, h, lp, a1, a2, a3, bus_a.out2, bus_a.out_valid, bus_a.toggle_cnt,
             bus_b.out2, bus_b.out_valid, bus_b.toggle_cnt);
    @(negedge clk);
    #1;
    check("clkout_lo", {30'h0, clkout_a, clkout_b}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) m_s[i][k] = 4'h0;
      m_fill[i] = 0;
      m_cnt[i]  = 0;
    end
    rst_n = 1'b0;
    @(negedge clk);

    // 1: basic DEPTH=2 behaviour (F, then 0, then steady)
    step(0, 0, 0, 4'hF, 4'hF, 4'h0);
    step(0, 1, 0, 4'hF, 4'hF, 4'h0);
    for (int n = 0; n < 5; n++) step(1, 0, 0, 4'hF, 4'hF, 4'h0);

    // 2: hold for three edges after the first, then release
    step(0, 0, 0, 4'hF, 4'hF, 4'h0);
    step(1, 0, 0, 4'hF, 4'hF, 4'h0);
    for (int n = 0; n < 3; n++) step(1, 1, 0, 4'hF, 4'hF, 4'h0);
    for (int n = 0; n < 4; n++) step(1, 0, 0, 4'hF, 4'hF, 4'h0);

    // 3: in2=0 forces all-ones after the first stage
    step(0, 0, 0, 4'hA, 4'h0, 4'h3);
    for (int n = 0; n < 5; n++) step(1, 0, 0, 4'hA, 4'h0, 4'(n * 3));

    // 4: loop oscillation and counter saturation on the CNT_W=2 pipe
    step(0, 0, 1, 4'hF, 4'hF, 4'h0);
    for (int n = 0; n < 6; n++) step(1, 0, 1, 4'hF, 4'hF, 4'h0);
    step(1, 0, 1, 4'hF, 4'hF, 4'hF);

    // 5: hold, combinational out1 under hold, then reset while held
    step(1, 1, 0, 4'h5, 4'h6, 4'h9);
    bus_a.in1 = 4'h0; bus_b.in1 = 4'h0;
    #1;
    check("a_out1_comb", {28'h0, bus_a.out1}, 32'hF);
    check("b_out1_comb", {28'h0, bus_b.out1}, 32'hF);
    step(0, 1, 0, 4'hF, 4'hF, 4'h9);
    step(1, 0, 0, 4'hF, 4'hF, 4'h0);

    // 6: single-cycle in3 pulse through the DEPTH=4 pipe
    step(0, 0, 0, 4'hF, 4'hF, 4'h0);
    for (int n = 0; n < 3; n++) step(1, 0, 0, 4'hF, 4'hF, 4'h0);
    step(1, 0, 0, 4'hF, 4'hF, 4'hF);
    for (int n = 0; n < 6; n++) step(1, 0, 0, 4'hF, 4'hF, 4'h0);

    // mixed random traffic
    for (int n = 0; n < 60; n++)
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0), 1'($urandom()),
           4'($urandom()), 4'($urandom()), 4'($urandom()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
